// File: rtl/nios_system_sysinfo.sv
// System information slave for the Nios system.
// It is an Avalon-MM register block that holds:
//   - the ID and build timestamp,
//   - a scratch register,
//   - a 64-bit uptime counter with a coherent high-word shadow,
//   - a control register for clearing and halting the counter,
//   - a parameter readback word.
// Reads are fully pipelined with a fixed latency of READ_LATENCY cycles and never stall.
module nios_system_sysinfo #(
    parameter logic [31:0] SYSTEM_ID    = 32'h0000000F,
    parameter logic [31:0] TIMESTAMP    = 32'd1411317456,
    parameter int          ADDR_W       = 3,
    parameter int          READ_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    localparam logic [7:0] ADDR_ID        = 8'd0;
    localparam logic [7:0] ADDR_TIMESTAMP = 8'd1;
    localparam logic [7:0] ADDR_SCRATCH   = 8'd2;
    localparam logic [7:0] ADDR_UP_LO     = 8'd3;
    localparam logic [7:0] ADDR_UP_HI     = 8'd4;
    localparam logic [7:0] ADDR_CONTROL   = 8'd5;
    localparam logic [7:0] ADDR_PARAM     = 8'd6;

    localparam logic [3:0]  LAT_NIBBLE = 4'(READ_LATENCY);
    localparam logic [3:0]  AW_NIBBLE  = 4'(ADDR_W);
    localparam logic [31:0] PARAM_WORD = {24'h0, LAT_NIBBLE, AW_NIBBLE};

    // Stages in front of the output register. Latency 1 needs none, so the index is clamped.
    localparam int LAST = (READ_LATENCY > 1) ? READ_LATENCY - 2 : 0;

    logic [7:0]  addr_ext;
    logic [31:0] scratch;
    logic        halt;
    logic [63:0] uptime;
    logic [31:0] uptime_hi_shadow;
    logic [31:0] read_mux;
    logic        scratch_we;
    logic        control_we;
    logic        clear_req;
    logic        pipe_valid [3];
    logic [31:0] pipe_data  [3];
    logic        final_valid;
    logic [31:0] final_data;

    assign addr_ext   = 8'(address);
    assign scratch_we = write && (addr_ext == ADDR_SCRATCH);
    assign control_we = write && (addr_ext == ADDR_CONTROL) && byteenable[0];
    assign clear_req  = control_we && writedata[0];

    // Select the read word from the register values in place before this edge.
    // A write in the same cycle therefore cannot affect the value returned.
    always_comb begin
        read_mux = 32'h0;
        case (addr_ext)
            ADDR_ID:        read_mux = SYSTEM_ID;
            ADDR_TIMESTAMP: read_mux = TIMESTAMP;
            ADDR_SCRATCH:   read_mux = scratch;
            ADDR_UP_LO:     read_mux = uptime[31:0];
            ADDR_UP_HI:     read_mux = uptime_hi_shadow;
            ADDR_CONTROL:   read_mux = {30'h0, halt, 1'b0};
            ADDR_PARAM:     read_mux = PARAM_WORD;
            default:        read_mux = 32'h0;
        endcase
    end

    // Scratch register, written per enabled byte lane.
    always_ff @(posedge clock) begin
        if (reset) begin
            scratch <= 32'h0;
        end else if (scratch_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    scratch[8*i +: 8] <= writedata[8*i +: 8];
                end
            end
        end
    end

    // Halt is the only stored control bit. The clear bit acts as a pulse and is never held.
    always_ff @(posedge clock) begin
        if (reset) begin
            halt <= 1'b0;
        end else if (control_we) begin
            halt <= writedata[1];
        end
    end

    // Uptime counter. Clear wins over halt, and the counter wraps naturally at 2^64.
    always_ff @(posedge clock) begin
        if (reset) begin
            uptime <= 64'h0;
        end else if (clear_req) begin
            uptime <= 64'h0;
        end else if (!halt) begin
            uptime <= uptime + 64'd1;
        end
    end

    // Reading the low word captures the high word.
    // A later high-word read then pairs with that same low-word sample.
    always_ff @(posedge clock) begin
        if (reset) begin
            uptime_hi_shadow <= 32'h0;
        end else if (read && (addr_ext == ADDR_UP_LO)) begin
            uptime_hi_shadow <= uptime[63:32];
        end
    end

    // Delay line for read data and valid. Reset flushes every in-flight read.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_data[i]  <= 32'h0;
            end
        end else begin
            pipe_valid[0] <= read;
            if (read) begin
                pipe_data[0] <= read_mux;
            end
            for (int i = 1; i < 3; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
        end
    end

    assign final_valid = (READ_LATENCY == 1) ? read     : pipe_valid[LAST];
    assign final_data  = (READ_LATENCY == 1) ? read_mux : pipe_data[LAST];

    // Output register. Readdata only changes when a result is delivered, so it holds between reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata      <= 32'h0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= final_valid;
            if (final_valid) begin
                readdata <= final_data;
            end
        end
    end

endmodule

// File: tb/tb_nios_system_sysinfo.sv
// Directed testbench for nios_system_sysinfo.
// Four instances with read latencies 1 to 4 share the same inputs.
// Most checks target the latency-1 instance; the others cover latency and flush behaviour.
module tb_nios_system_sysinfo;

    logic        clock;
    logic        reset;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] rd_all  [1:4];
    logic        rdv_all [1:4];

    int checks;
    int fails;

    localparam logic [31:0] EXP_ID = 32'h0000000F;
    localparam logic [31:0] EXP_TS = 32'd1411317456;

    nios_system_sysinfo #(.READ_LATENCY(1)) u_lat1 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_all[1]), .readdatavalid(rdv_all[1])
    );
    nios_system_sysinfo #(.READ_LATENCY(2)) u_lat2 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_all[2]), .readdatavalid(rdv_all[2])
    );
    nios_system_sysinfo #(.READ_LATENCY(3)) u_lat3 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_all[3]), .readdatavalid(rdv_all[3])
    );
    nios_system_sysinfo #(.READ_LATENCY(4)) u_lat4 (
        .clock(clock), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .readdata(rd_all[4]), .readdatavalid(rdv_all[4])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one bus cycle at a falling edge, then wait for the next falling edge.
    // After the wait, the latency-1 outputs show this cycle's result.
    task automatic drive(input logic rd, input logic wr, input logic [2:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        read       = rd;
        write      = wr;
        address    = addr;
        writedata  = wd;
        byteenable = be;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        read  = 1'b1;
        address = 3'd0;
        repeat (3) @(negedge clock);
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (rdv_all[i] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_valid lat%0d: got %b expected 0", i, rdv_all[i]);
            end
            checks++;
            if (rd_all[i] !== 32'h0) begin
                fails++;
                $display("[TB] FAIL reset_data lat%0d: got %h expected 0", i, rd_all[i]);
            end
        end
        // Releasing reset and reading UPTIME_LO at once samples 0, then 1, then 2.
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
            checks++;
            if (rdv_all[1] !== 1'b1 || rd_all[1] !== 32'(n)) begin
                fails++;
                $display("[TB] FAIL uptime_after_reset %0d: got v=%b d=%h expected v=1 d=%h",
                         n, rdv_all[1], rd_all[1], 32'(n));
            end
        end
        drive(1'b1, 1'b0, 3'd5, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL control_after_reset: got %h expected 0", rd_all[1]);
        end
    endtask

    task automatic test_id_regs;
        drive(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        checks++;
        if (rdv_all[1] !== 1'b1 || rd_all[1] !== EXP_ID) begin
            fails++;
            $display("[TB] FAIL id: got v=%b d=%h expected v=1 d=%h", rdv_all[1], rd_all[1], EXP_ID);
        end
        drive(1'b1, 1'b0, 3'd1, 32'h0, 4'h0);
        checks++;
        if (rdv_all[1] !== 1'b1 || rd_all[1] !== EXP_TS) begin
            fails++;
            $display("[TB] FAIL timestamp: got v=%b d=%h expected v=1 d=%h", rdv_all[1], rd_all[1], EXP_TS);
        end
        drive(1'b1, 1'b0, 3'd6, 32'h0, 4'h0);
        checks++;
        if (rdv_all[1] !== 1'b1 || rd_all[1] !== 32'h00000013) begin
            fails++;
            $display("[TB] FAIL param: got v=%b d=%h expected v=1 d=00000013", rdv_all[1], rd_all[1]);
        end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        checks++;
        if (rdv_all[1] !== 1'b0 || rd_all[1] !== 32'h00000013) begin
            fails++;
            $display("[TB] FAIL hold_readdata: got v=%b d=%h expected v=0 d=00000013", rdv_all[1], rd_all[1]);
        end
        drive(1'b1, 1'b0, 3'd7, 32'h0, 4'h0);
        checks++;
        if (rdv_all[1] !== 1'b1 || rd_all[1] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL unmapped_read: got v=%b d=%h expected v=1 d=0", rdv_all[1], rd_all[1]);
        end
        drive(1'b0, 1'b1, 3'd0, 32'h12345678, 4'hF);
        drive(1'b0, 1'b1, 3'd6, 32'h12345678, 4'hF);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== EXP_ID) begin
            fails++;
            $display("[TB] FAIL ro_write_id: got %h expected %h", rd_all[1], EXP_ID);
        end
        drive(1'b1, 1'b0, 3'd6, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h00000013) begin
            fails++;
            $display("[TB] FAIL ro_write_param: got %h expected 00000013", rd_all[1]);
        end
    endtask

    task automatic test_scratch;
        drive(1'b0, 1'b1, 3'd2, 32'hAABBCCDD, 4'b1111);
        drive(1'b0, 1'b1, 3'd2, 32'h11223344, 4'b0101);
        drive(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'hAA22CC44) begin
            fails++;
            $display("[TB] FAIL scratch_lanes: got %h expected aa22cc44", rd_all[1]);
        end
        drive(1'b1, 1'b1, 3'd2, 32'h55667788, 4'b1111);
        checks++;
        if (rd_all[1] !== 32'hAA22CC44) begin
            fails++;
            $display("[TB] FAIL scratch_read_during_write: got %h expected aa22cc44", rd_all[1]);
        end
        drive(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h55667788) begin
            fails++;
            $display("[TB] FAIL scratch_new_value: got %h expected 55667788", rd_all[1]);
        end
        drive(1'b0, 1'b1, 3'd2, 32'hFFFFFFFF, 4'b0000);
        drive(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h55667788) begin
            fails++;
            $display("[TB] FAIL scratch_no_lanes: got %h expected 55667788", rd_all[1]);
        end
    endtask

    task automatic test_clear_halt;
        // Clear together with halt: the counter goes to 0 and stays there.
        drive(1'b0, 1'b1, 3'd5, 32'hFFFFFFFF, 4'b0001);
        drive(1'b1, 1'b0, 3'd5, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h00000002) begin
            fails++;
            $display("[TB] FAIL control_readback: got %h expected 00000002", rd_all[1]);
        end
        drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL halted_after_clear: got %h expected 0", rd_all[1]);
        end
        repeat (5) drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL halted_hold: got %h expected 0", rd_all[1]);
        end
        // A control write without lane 0 is ignored, so halt stays set.
        drive(1'b0, 1'b1, 3'd5, 32'h0, 4'b1110);
        drive(1'b1, 1'b0, 3'd5, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h00000002) begin
            fails++;
            $display("[TB] FAIL control_lane0_only: got %h expected 00000002", rd_all[1]);
        end
        drive(1'b0, 1'b1, 3'd5, 32'h0, 4'b0001);
        for (int n = 0; n < 3; n++) begin
            drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
            checks++;
            if (rd_all[1] !== 32'(n)) begin
                fails++;
                $display("[TB] FAIL resume_count %0d: got %h expected %h", n, rd_all[1], 32'(n));
            end
        end
        // Clear alone restarts counting from 0.
        repeat (4) drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 3'd5, 32'h00000001, 4'b0001);
        drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL clear_only: got %h expected 0", rd_all[1]);
        end
        drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h1) begin
            fails++;
            $display("[TB] FAIL clear_only_next: got %h expected 1", rd_all[1]);
        end
    endtask

    task automatic test_uptime_coherence;
        force u_lat1.uptime = 64'h00000007_FFFFFFFF;
        drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        release u_lat1.uptime;
        checks++;
        if (rd_all[1] !== 32'hFFFFFFFF) begin
            fails++;
            $display("[TB] FAIL uptime_lo_sample: got %h expected ffffffff", rd_all[1]);
        end
        repeat (10) drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        checks++;
        if (rdv_all[1] !== 1'b0 || rd_all[1] !== 32'hFFFFFFFF) begin
            fails++;
            $display("[TB] FAIL idle_hold: got v=%b d=%h expected v=0 d=ffffffff", rdv_all[1], rd_all[1]);
        end
        drive(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h00000007) begin
            fails++;
            $display("[TB] FAIL uptime_hi_shadow: got %h expected 00000007", rd_all[1]);
        end
        drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h00000008) begin
            fails++;
            $display("[TB] FAIL uptime_hi_carry: got %h expected 00000008", rd_all[1]);
        end
        // Wrap from all ones.
        // The value seen just after release may differ by one between simulators, so LO accepts 0 or 1.
        force u_lat1.uptime = 64'hFFFFFFFF_FFFFFFFF;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        release u_lat1.uptime;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 3'd3, 32'h0, 4'h0);
        checks++;
        if (rdv_all[1] !== 1'b1 || rd_all[1] > 32'd1) begin
            fails++;
            $display("[TB] FAIL wrap_lo: got v=%b d=%h expected v=1 d<=1", rdv_all[1], rd_all[1]);
        end
        drive(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL wrap_hi: got %h expected 0", rd_all[1]);
        end
    endtask

    task automatic test_latency_sweep;
        repeat (6) drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        read    = 1'b1;
        address = 3'd0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clock);
            read = 1'b0;
            for (int n = 1; n <= 4; n++) begin
                checks++;
                if (rdv_all[n] !== (cyc == n)) begin
                    fails++;
                    $display("[TB] FAIL latency%0d_cycle%0d valid: got %b expected %b",
                             n, cyc, rdv_all[n], (cyc == n));
                end
                if (cyc == n) begin
                    checks++;
                    if (rd_all[n] !== EXP_ID) begin
                        fails++;
                        $display("[TB] FAIL latency%0d data: got %h expected %h", n, rd_all[n], EXP_ID);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_seq [3];
        logic [2:0]  addr_seq [3];
        exp_seq[0]  = EXP_ID;
        exp_seq[1]  = EXP_TS;
        exp_seq[2]  = 32'h00000033;
        addr_seq[0] = 3'd0;
        addr_seq[1] = 3'd1;
        addr_seq[2] = 3'd6;
        repeat (6) drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        read    = 1'b1;
        address = addr_seq[0];
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clock);
            if (cyc < 3) begin
                address = addr_seq[cyc];
            end else begin
                read = 1'b0;
            end
            checks++;
            if (rdv_all[3] !== (cyc >= 3 && cyc <= 5)) begin
                fails++;
                $display("[TB] FAIL b2b_lat3 cycle%0d valid: got %b", cyc, rdv_all[3]);
            end
            if (cyc >= 3 && cyc <= 5) begin
                checks++;
                if (rd_all[3] !== exp_seq[cyc-3]) begin
                    fails++;
                    $display("[TB] FAIL b2b_lat3 cycle%0d data: got %h expected %h",
                             cyc, rd_all[3], exp_seq[cyc-3]);
                end
            end
        end
    endtask

    task automatic test_reset_flush;
        repeat (6) drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        drive(1'b0, 1'b1, 3'd2, 32'hDEADBEEF, 4'hF);
        drive(1'b1, 1'b0, 3'd0, 32'h0, 4'h0);
        reset = 1'b1;
        drive(1'b1, 1'b0, 3'd1, 32'h0, 4'h0);
        drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
        for (int n = 1; n <= 4; n++) begin
            checks++;
            if (rdv_all[n] !== 1'b0 || rd_all[n] !== 32'h0) begin
                fails++;
                $display("[TB] FAIL flush_in_reset lat%0d: got v=%b d=%h expected v=0 d=0",
                         n, rdv_all[n], rd_all[n]);
            end
        end
        reset = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            drive(1'b0, 1'b0, 3'd0, 32'h0, 4'h0);
            for (int n = 1; n <= 4; n++) begin
                checks++;
                if (rdv_all[n] !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL flush_after_reset lat%0d cycle%0d: got %b expected 0",
                             n, cyc, rdv_all[n]);
                end
            end
        end
        drive(1'b1, 1'b0, 3'd2, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL scratch_after_reset: got %h expected 0", rd_all[1]);
        end
        drive(1'b1, 1'b0, 3'd4, 32'h0, 4'h0);
        checks++;
        if (rd_all[1] !== 32'h0) begin
            fails++;
            $display("[TB] FAIL shadow_after_reset: got %h expected 0", rd_all[1]);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks     = 0;
        fails      = 0;
        reset      = 1'b1;
        read       = 1'b0;
        write      = 1'b0;
        address    = 3'd0;
        writedata  = 32'h0;
        byteenable = 4'h0;
        test_reset();
        test_id_regs();
        test_scratch();
        test_clear_halt();
        test_uptime_coherence();
        test_latency_sweep();
        test_back_to_back();
        test_reset_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/nios_system_sysinfo.md
NIOS_SYSTEM_SYSINFO -- requirements
Module: nios_system_sysinfo

Interface
REQ-001 SHALL have parameter SYSTEM_ID, default 32'h0000000F, the 32-bit system identifier.
REQ-002 SHALL have parameter TIMESTAMP, default 32'd1411317456, the 32-bit build timestamp.
REQ-003 SHALL have parameter ADDR_W, default 3, the word-address width; legal range 3..8.
REQ-004 SHALL have parameter READ_LATENCY, default 1, the cycles from read acceptance to readdatavalid; legal range 1..4.
REQ-005 SHALL have port clock, input, 1 bit, the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-007 SHALL have port address, input, ADDR_W bits, the Avalon-MM word address.
REQ-008 SHALL have port read, input, 1 bit, the read request; every asserted cycle is accepted.
REQ-009 SHALL have port write, input, 1 bit, the write request; every asserted cycle is accepted.
REQ-010 SHALL have port writedata, input, 32 bits, the write data.
REQ-011 SHALL have port byteenable, input, 4 bits, the write byte lanes.
REQ-012 SHALL have port readdata, output, 32 bits, the registered read data.
REQ-013 SHALL have port readdatavalid, output, 1 bit, high for exactly one cycle per accepted read.

Function
REQ-014 SHALL use this register map: 0 ID (RO, SYSTEM_ID); 1 TIMESTAMP (RO); 2 SCRATCH (RW); 3 UPTIME_LO (RO); 4 UPTIME_HI (RO shadow); 5 CONTROL (RW); 6 PARAM (RO).
REQ-015 SHALL return 0 for reads of addresses 7 and above, and SHALL ignore writes to RO or unmapped addresses.
REQ-016 SHALL return PARAM as {24'h0, READ_LATENCY[3:0], ADDR_W[3:0]}.
REQ-017 SHALL sample the read data on the cycle read is asserted and SHALL present it, with readdatavalid, exactly READ_LATENCY cycles later.
REQ-018 SHALL be fully pipelined: back-to-back reads return back-to-back in order, with no waitrequest.
REQ-019 SHALL keep readdata at its last value when readdatavalid is 0.
REQ-020 SHALL update SCRATCH per byte lane where byteenable[i]=1 on the cycle after the write.
REQ-021 SHALL, for a read and a write to the same address in one cycle, return the pre-write value.
REQ-022 SHALL implement a 64-bit uptime counter that increments by 1 each cycle when CONTROL.halt (bit 1) is 0.
REQ-023 SHALL wrap the uptime counter from 2^64-1 to 0 without any flag.
REQ-024 SHALL, when CONTROL bit 0 is written as 1, clear the counter to 0 on the next edge; bit 0 self-clears and reads as 0.
REQ-025 SHALL, when clear and halt are set in the same write, give clear precedence; the counter then holds 0.
REQ-026 SHALL, on a read of UPTIME_LO, return counter[31:0] and latch counter[63:32] into the UPTIME_HI shadow at the same sampling edge.
REQ-027 SHALL return the shadow on reads of UPTIME_HI; the shadow is unaffected by counter activity between the two reads.
REQ-028 SHALL implement CONTROL bits 31:2 as read-as-0; the CONTROL write honours byteenable[0] only.

Reset
REQ-029 SHALL, while reset is high, set readdata=0, readdatavalid=0, SCRATCH=0, CONTROL=0, counter=0 and shadow=0.
REQ-030 SHALL, on reset mid-operation, flush all in-flight reads, so that no readdatavalid is produced for reads accepted before or during reset.
REQ-031 SHALL start counting on the first edge after reset deasserts (counter=1 one cycle after release).

Verification
REQ-032 SHALL verify ID/TIMESTAMP/PARAM: with READ_LATENCY=1, read addresses 0, 1, 6 back-to-back -> 32'h0000000F, 32'd1411317456, 32'h00000013 on three consecutive readdatavalid cycles.
REQ-033 SHALL verify latency sweep: for READ_LATENCY=1..4, a single read of address 0 -> readdatavalid exactly N cycles later, for one cycle.
REQ-034 SHALL verify SCRATCH byte lanes: write 32'hAABBCCDD with be=4'b1111, then 32'h11223344 with be=4'b0101, then read -> 32'hAA22CC44; a same-cycle read/write returns the old value.
REQ-035 SHALL verify uptime coherence: force the counter to 32'hFFFFFFFF in the low word, read LO, wait 10 cycles, read HI -> HI equals the value at LO sampling; verify the 2^64-1 to 0 wrap.
REQ-036 SHALL verify clear/halt: write CONTROL=3 -> counter 0 and held; write CONTROL=0 -> counts resume from 0; reset asserted with 2 reads in flight -> no readdatavalid and all outputs 0.
